// File: rtl/ysyx_22050039_ifu_pkg.sv
// ============================================================================
// Module  : ysyx_22050039_ifu_pkg
// Brief   : Shared fetch-unit types and default constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22050039_ifu_pkg;

    localparam int unsigned    IFU_XLEN     = 64;
    localparam int unsigned    IFU_INST_LEN = 32;
    localparam logic [63:0]    IFU_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } Ifu_state;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050039_Reg.sv
// ============================================================================
// Module  : ysyx_22050039_Reg
// Brief   : Write-enabled register with synchronous reset to a fixed value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050039_Reg #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RESET_VAL;
        end else if (wen_i) begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050039_ifu.sv
// ============================================================================
// Module  : ysyx_22050039_ifu
// Brief   : Single-outstanding instruction fetch unit with redirect/kill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050039_ifu
    import ysyx_22050039_ifu_pkg::*;
#(
    parameter int unsigned      XLEN     = IFU_XLEN,
    parameter int unsigned      INST_LEN = IFU_INST_LEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [INST_LEN-1:0] mem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic                fetch_fault
);

    Ifu_state            state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                pc_wen;
    logic                kill_q, kill_d;
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
    logic                redir_ok, redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    ysyx_22050039_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .wen_i (pc_wen),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_wen    = 1'b0;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        if (state_q != FAULT && redir_bad) begin
            state_d = FAULT;
            pc_d    = redirect_pc;
            pc_wen  = 1'b1;
        end else begin
            case (state_q)
                REQ: begin
                    if (redir_ok) begin
                        pc_d   = redirect_pc;
                        pc_wen = 1'b1;
                    end
                    // A request accepted alongside a redirect carries the old PC.
                    if (mem_req_ready) begin
                        state_d = WAIT;
                        kill_d  = redir_ok;
                    end
                end
                WAIT: begin
                    if (redir_ok) begin
                        pc_d   = redirect_pc;
                        pc_wen = 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        kill_d = 1'b0;
                        if (kill_q || redir_ok) begin
                            state_d = REQ;
                        end else begin
                            inst_d    = mem_rsp_data;
                            inst_pc_d = pc_q;
                            state_d   = HOLD;
                        end
                    end else if (redir_ok) begin
                        kill_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (redir_ok) begin
                        pc_d    = redirect_pc;
                        pc_wen  = 1'b1;
                        state_d = REQ;
                    end else if (inst_ready) begin
                        pc_d    = pc_q + XLEN'(4);
                        pc_wen  = 1'b1;
                        state_d = REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req_valid = (state_q == REQ) && !rst;
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_fault   = (state_q == FAULT);

    a_no_rsp_on_accept: assert property (@(posedge clk) disable iff (rst)
        !(state_q == REQ && mem_req_ready && mem_rsp_valid));

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050039_ifu.sv
// ============================================================================
// Module  : tb_ysyx_22050039_ifu
// Brief   : Directed and randomized checks of the fetch unit against a
//           transaction-level fetch model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050039_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    // Fetch model: architectural next-fetch PC plus outstanding/held bookkeeping.
    bit          m_fault = 0, m_out = 0, m_stale = 0, m_held = 0;
    logic [63:0] m_pc = RST_PC, m_req_addr = '0, m_inst_pc = '0;
    logic [31:0] m_inst = '0;

    bit          mem_auto = 0, mem_pend = 0;
    int          mem_cnt = 0, mem_lat = 1;
    logic [31:0] mem_data = '0;
    logic [31:0] last_inst;

    ysyx_22050039_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic bit exp_req();
        return !rst && !m_fault && !m_out && !m_held;
    endfunction

    // Applies the current inputs for one cycle, advances the model, and
    // returns at the next falling edge.
    task automatic tick();
        bit fire;
        if (mem_auto) begin
            mem_rsp_valid = 1'b0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_data;
                    mem_pend      = 0;
                end
            end
        end
        fire = exp_req() && mem_req_ready;
        if (rst) begin
            m_fault = 0; m_out = 0; m_stale = 0; m_held = 0;
            m_pc = RST_PC; m_inst = '0; m_inst_pc = '0;
        end else if (!m_fault) begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
                m_fault = 1; m_out = 0; m_held = 0; m_pc = redirect_pc;
            end else if (m_held) begin
                if (redirect_valid) begin
                    m_held = 0; m_pc = redirect_pc;
                end else if (inst_ready) begin
                    m_held = 0; m_pc = m_pc + 64'd4;
                end
            end else if (m_out) begin
                if (mem_rsp_valid) begin
                    m_out = 0;
                    if (!m_stale && !redirect_valid) begin
                        m_held = 1; m_inst = mem_rsp_data; m_inst_pc = m_req_addr;
                    end
                    m_stale = 0;
                end else if (redirect_valid) begin
                    m_stale = 1;
                end
                if (redirect_valid) m_pc = redirect_pc;
            end else begin
                if (mem_req_ready) begin
                    m_out = 1; m_req_addr = m_pc; m_stale = redirect_valid;
                end
                if (redirect_valid) m_pc = redirect_pc;
            end
        end
        if (mem_auto && fire) begin
            mem_pend = 1;
            mem_cnt  = mem_lat;
            mem_data = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got req=%b iv=%b ff=%b expected 0 0 0", mem_req_valid, inst_valid, fetch_fault);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got inst=%h pc=%h expected 0 0", inst, inst_pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_first_req got v=%b a=%h expected 1 %h", mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC + 64'(4 * k)) begin
                failures++;
                $display("FAIL basic_req%0d got v=%b a=%h expected 1 %h", k, mem_req_valid, mem_req_addr, RST_PC + 64'(4 * k));
            end
            mem_req_ready = 1'b1; inst_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            checks++;
            if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_wait%0d got iv=%b req=%b expected 0 0", k, inst_valid, mem_req_valid);
            end
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
            tick();
            mem_rsp_valid = 1'b0;
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== RST_PC + 64'(4 * k)) begin
                failures++;
                $display("FAIL basic_inst%0d got iv=%b inst=%h pc=%h expected 1 00000413 %h", k, inst_valid, inst, inst_pc, RST_PC + 64'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_slow();
        logic [31:0] d;
        mem_req_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_000C) begin
            failures++;
            $display("FAIL slow_pending got v=%b a=%h expected 1 8000000c", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL slow_wait%0d got req=%b iv=%b expected 0 0", i, mem_req_valid, inst_valid);
            end
        end
        mem_req_ready = 1'b0;
        d = $urandom;
        mem_rsp_valid = 1'b1; mem_rsp_data = d;
        tick();
        mem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== 64'h8000_000C || mem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL slow_hold%0d got iv=%b inst=%h pc=%h req=%b expected 1 %h 8000000c 0", i, inst_valid, inst, inst_pc, mem_req_valid, d);
            end
            if (i < 4) tick();
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL slow_next got v=%b a=%h iv=%b expected 1 80000010 0", mem_req_valid, mem_req_addr, inst_valid);
        end
        last_inst = d;
    endtask

    task automatic test_redirect();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_wait_hold got req=%b expected 0", mem_req_valid);
        end
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100 || inst !== last_inst) begin
            failures++;
            $display("FAIL redir_wait_drop got iv=%b v=%b a=%h inst=%h expected 0 1 80000100 %h", inst_valid, mem_req_valid, mem_req_addr, inst, last_inst);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0100 || inst !== 32'h0010_0093) begin
            failures++;
            $display("FAIL redir_refetch got iv=%b pc=%h inst=%h expected 1 80000100 00100093", inst_valid, inst_pc, inst);
        end
        // Redirect beats a same-cycle consume in HOLD.
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
            failures++;
            $display("FAIL redir_hold got iv=%b v=%b a=%h expected 0 1 80000200", inst_valid, mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1; redirect_pc = 64'h8000_0300;
        tick();
        mem_req_ready = 1'b0; redirect_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0BAD;
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0300) begin
            failures++;
            $display("FAIL redir_req_accept got iv=%b v=%b a=%h expected 0 1 80000300", inst_valid, mem_req_valid, mem_req_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0400) begin
            failures++;
            $display("FAIL redir_req_idle got v=%b a=%h expected 1 80000400", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0500; mem_rsp_valid = 1'b1;
        tick();
        redirect_valid = 1'b0; mem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0500) begin
            failures++;
            $display("FAIL redir_wait_rsp got iv=%b v=%b a=%h expected 0 1 80000500", inst_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_inst got iv=%b pc=%h expected 1 fffffffffffffffc", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0) begin
            failures++;
            $display("FAIL wrap_next got v=%b a=%h expected 1 0", mem_req_valid, mem_req_addr);
        end
        redirect_valid = 1'b1; redirect_pc = RST_PC;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_random();
        mem_auto = 1; mem_pend = 0;
        for (int i = 0; i < 1000; i++) begin
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            mem_lat        = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = RST_PC + (64'($urandom_range(0, 1023)) << 2);
            tick();
            checks++;
            if (mem_req_valid !== exp_req() || (exp_req() && mem_req_addr !== m_pc)) begin
                failures++;
                $display("FAIL rand_req cyc=%0d got v=%b a=%h expected %b %h", i, mem_req_valid, mem_req_addr, exp_req(), m_pc);
            end
            checks++;
            if (inst_valid !== (m_held && !m_fault) || inst !== m_inst || inst_pc !== m_inst_pc) begin
                failures++;
                $display("FAIL rand_inst cyc=%0d got iv=%b inst=%h pc=%h expected %b %h %h", i, inst_valid, inst, inst_pc, m_held, m_inst, m_inst_pc);
            end
            checks++;
            if (fetch_fault !== 1'b0) begin
                failures++;
                $display("FAIL rand_fault cyc=%0d got %b expected 0", i, fetch_fault);
            end
        end
        mem_auto = 0; redirect_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        tick();
        checks++;
        if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_enter got ff=%b v=%b iv=%b expected 1 0 0", fetch_fault, mem_req_valid, inst_valid);
        end
        for (int i = 0; i < 10; i++) begin
            mem_req_ready  = 1'b1;
            inst_ready     = 1'b1;
            mem_rsp_valid  = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = RST_PC;
            tick();
            checks++;
            if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL fault_sticky%0d got ff=%b v=%b iv=%b expected 1 0 0", i, fetch_fault, mem_req_valid, inst_valid);
            end
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_reset got ff=%b v=%b expected 0 0", fetch_fault, mem_req_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL fault_restart got v=%b a=%h expected 1 %h", mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0; inst_ready = 1'b1;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (inst !== 32'h0 || inst_pc !== 64'h0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got inst=%h pc=%h iv=%b v=%b ff=%b expected 0 0 0 0 0", inst, inst_pc, inst_valid, mem_req_valid, fetch_fault);
        end
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL rstmid_late_rsp got iv=%b inst=%h v=%b a=%h expected 0 0 1 %h", inst_valid, inst, mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_redirect();
        test_wrap();
        test_random();
        test_fault();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
